// File: rtl/oric_mem_pkg.sv
// Shared types and defaults for the Oric main-RAM sequencer/arbiter.
package oric_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2
  } arb_state_t;

  localparam int         ORIC_RAM_AW   = 16;
  localparam logic [7:0] ORIC_RAM_FILL = 8'hFF;

endpackage

// File: rtl/oric_dl_fifo.sv
// Small synchronous FIFO for download writes: wrap-around pointers with one
// extra bit, no bypass, flush empties it in one cycle.
module oric_dl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/oric_ram_arbiter.sv
// Main-RAM sequencer: fills the array after reset/clr_req, merges download
// writes through a FIFO, and otherwise hands the single port to the CPU.
module oric_ram_arbiter
  import oric_mem_pkg::*;
#(
  parameter int         ADDR_W     = ORIC_RAM_AW,
  parameter logic [7:0] FILL       = ORIC_RAM_FILL,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              cpu_hold,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_q
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + 8;

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              dl_active_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ENT_W-1:0]  fifo_head;
  logic [PTR_W-1:0]  fifo_count, fifo_cnt_next;
  logic [ADDR_W-1:0] head_addr;
  logic [7:0]        head_data;
  logic              mem_we_raw;

  assign {head_addr, head_data} = fifo_head;

  // Valid/ready on the download port: a beat transfers when dl_wr & dl_ready
  // are both high at a clk_sys edge; clr_req in that cycle discards it.
  assign dl_ready      = ~fifo_full & (state_q != CLEAR);
  assign fifo_push     = dl_wr & dl_ready & ~clr_req;
  assign fifo_pop      = (state_q == LOAD) & ~cpu_cs & ~fifo_empty & ~clr_req;
  assign fifo_cnt_next = fifo_count + PTR_W'(fifo_push) - PTR_W'(fifo_pop);

  oric_dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .flush_i (clr_req),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({dl_addr, dl_data}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      dl_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      dl_active_q <= dl_active;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clr_req) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (&clr_cnt_q) state_d = dl_active ? LOAD : IDLE;
        end
        IDLE: if (dl_active && !dl_active_q) state_d = LOAD;
        // Leave on the edge of the last pop so the CPU is released right after it.
        LOAD: if (!dl_active && (fifo_cnt_next == '0)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr   = cpu_addr;
    mem_din    = cpu_din;
    mem_we_raw = 1'b0;
    if (state_q == CLEAR) begin
      mem_addr   = clr_cnt_q;
      mem_din    = FILL;
      mem_we_raw = 1'b1;
    end else if (cpu_cs) begin
      mem_we_raw = cpu_we;
    end else if (fifo_pop) begin
      mem_addr   = head_addr;
      mem_din    = head_data;
      mem_we_raw = 1'b1;
    end
  end

  assign mem_we   = mem_we_raw & reset_n;
  assign cpu_dout = mem_q;
  assign clr_busy = (state_q == CLEAR);
  assign cpu_hold = (state_q != IDLE);

endmodule
